// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - bfloat16 field widths, class encoding and special-product resolution
package bf16_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 7;
  localparam int EXP_INT_W = 10;
  localparam int BF16_W    = 1 + EXP_W + MAN_W;
  localparam int BIAS      = 127;

  // Class vector layout {nan, inf, sub, zero}; all-zero means normal.
  localparam int CLS_W    = 4;
  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_INF  = 2;
  localparam int CLS_NAN  = 3;

  localparam logic [BF16_W-1:0] BF16_QNAN    = 16'h7FC0;
  localparam logic [EXP_W-1:0]  BF16_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              valid;
    logic [BF16_W-1:0] result;
  } special_t;

  // NaN-producing cases win over infinity, which wins over zero.
  function automatic special_t resolve_special(input logic [CLS_W-1:0] ca,
                                               input logic [CLS_W-1:0] cb,
                                               input logic             psign);
    special_t r;
    logic nan_hit;
    logic inf_any;
    logic zero_any;
    nan_hit  = ca[CLS_NAN] | cb[CLS_NAN] |
               (ca[CLS_INF] & cb[CLS_ZERO]) | (cb[CLS_INF] & ca[CLS_ZERO]);
    inf_any  = ca[CLS_INF] | cb[CLS_INF];
    zero_any = ca[CLS_ZERO] | cb[CLS_ZERO];
    if (nan_hit) begin
      r.valid  = 1'b1;
      r.result = BF16_QNAN;
    end else if (inf_any) begin
      r.valid  = 1'b1;
      r.result = {psign, BF16_EXP_MAX, {MAN_W{1'b0}}};
    end else if (zero_any) begin
      r.valid  = 1'b1;
      r.result = {psign, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
    end else begin
      r.valid  = 1'b0;
      r.result = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bf16_field_decode.sv
// rtl/bf16_field_decode.sv - combinational bfloat16 operand decoder
// BF16_DAZ_EN: when defined, subnormal inputs decode as zero.
module bf16_field_decode
  import bf16_pkg::*;
(
  input  logic [BF16_W-1:0]    op,
  output logic                 sign,
  output logic [EXP_INT_W-1:0] exp,
  output logic [MAN_W:0]       man,
  output logic [CLS_W-1:0]     cls
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  logic             e_zero;
  logic             e_max;
  logic             m_zero;

  assign sign   = op[BF16_W-1];
  assign e      = op[EXP_W+MAN_W-1:MAN_W];
  assign m      = op[MAN_W-1:0];
  assign e_zero = (e == '0);
  assign e_max  = (e == BF16_EXP_MAX);
  assign m_zero = (m == '0);

  always_comb begin
    cls = '0;
    exp = {{(EXP_INT_W-EXP_W){1'b0}}, e};
    man = {~e_zero, m};
    if (e_max) begin
      if (m_zero) cls[CLS_INF] = 1'b1;
      else        cls[CLS_NAN] = 1'b1;
    end else if (e_zero) begin
      if (m_zero) begin
        cls[CLS_ZERO] = 1'b1;
      end else begin
`ifdef BF16_DAZ_EN
        cls[CLS_ZERO] = 1'b1;
        exp           = '0;
        man           = '0;
`else
        // Subnormals share the scale of exponent 1, hidden bit stays 0.
        cls[CLS_SUB]  = 1'b1;
        exp           = EXP_INT_W'(1);
`endif
      end
    end
  end

endmodule

// File: rtl/bf16_operand_unpack.sv
// rtl/bf16_operand_unpack.sv - elastic two-stage bfloat16 operand decode with special-product bypass
// BF16_DAZ_EN: when defined, subnormal operands are flushed to zero in the decoder.
module bf16_operand_unpack
  import bf16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BF16_W-1:0]    a_in,
  input  logic [BF16_W-1:0]    b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 a_sign,
  output logic                 b_sign,
  output logic                 prod_sign,
  output logic [EXP_INT_W-1:0] a_exp,
  output logic [EXP_INT_W-1:0] b_exp,
  output logic [MAN_W:0]       a_man,
  output logic [MAN_W:0]       b_man,
  output logic [CLS_W-1:0]     a_cls,
  output logic [CLS_W-1:0]     b_cls,
  output logic                 special_valid,
  output logic [BF16_W-1:0]    special_result,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     special_cnt
);

  logic              s1_v;
  logic [BF16_W-1:0] s1_a;
  logic [BF16_W-1:0] s1_b;
  logic              s1_load;
  logic              s2_load;

  logic                 dec_a_sign;
  logic                 dec_b_sign;
  logic [EXP_INT_W-1:0] dec_a_exp;
  logic [EXP_INT_W-1:0] dec_b_exp;
  logic [MAN_W:0]       dec_a_man;
  logic [MAN_W:0]       dec_b_man;
  logic [CLS_W-1:0]     dec_a_cls;
  logic [CLS_W-1:0]     dec_b_cls;
  logic                 dec_psign;
  special_t             dec_spec;

  // Stage 2 may refill whenever it is empty or its content leaves this cycle.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_v || s2_load;
  assign in_ready = s1_load;

  bf16_field_decode u_dec_a (
    .op   (s1_a),
    .sign (dec_a_sign),
    .exp  (dec_a_exp),
    .man  (dec_a_man),
    .cls  (dec_a_cls)
  );

  bf16_field_decode u_dec_b (
    .op   (s1_b),
    .sign (dec_b_sign),
    .exp  (dec_b_exp),
    .man  (dec_b_man),
    .cls  (dec_b_cls)
  );

  assign dec_psign = dec_a_sign ^ dec_b_sign;
  assign dec_spec  = resolve_special(dec_a_cls, dec_b_cls, dec_psign);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
    end else if (s1_load) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a <= a_in;
        s1_b <= b_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      a_sign         <= 1'b0;
      b_sign         <= 1'b0;
      prod_sign      <= 1'b0;
      a_exp          <= '0;
      b_exp          <= '0;
      a_man          <= '0;
      b_man          <= '0;
      a_cls          <= '0;
      b_cls          <= '0;
      special_valid  <= 1'b0;
      special_result <= '0;
    end else if (s2_load) begin
      out_valid <= s1_v;
      // Data registers only move with a real pair, so bubbles leave them quiet.
      if (s1_v) begin
        a_sign         <= dec_a_sign;
        b_sign         <= dec_b_sign;
        prod_sign      <= dec_psign;
        a_exp          <= dec_a_exp;
        b_exp          <= dec_b_exp;
        a_man          <= dec_a_man;
        b_man          <= dec_b_man;
        a_cls          <= dec_a_cls;
        b_cls          <= dec_b_cls;
        special_valid  <= dec_spec.valid;
        special_result <= dec_spec.result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      special_cnt <= '0;
    end else if (cnt_clr) begin
      special_cnt <= '0;
    end else if (out_valid && out_ready && special_valid && (special_cnt != '1)) begin
      special_cnt <= special_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bf16_operand_unpack.sv
// tb/tb_bf16_operand_unpack.sv - scoreboard bench for bf16_operand_unpack
// BF16_DAZ_EN: reference model follows the same macro as the design.
`timescale 1ns/1ps
module tb_bf16_operand_unpack;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef BF16_DAZ_EN
  localparam bit DAZ = 1'b1;
`else
  localparam bit DAZ = 1'b0;
`endif
  localparam int C_NORM = 0, C_ZERO = 1, C_SUB = 2, C_INF = 3, C_NAN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic a_sign, b_sign, prod_sign;
  logic [9:0] a_exp, b_exp;
  logic [7:0] a_man, b_man;
  logic [3:0] a_cls, b_cls;
  logic special_valid;
  logic [15:0] special_result;
  logic cnt_clr = 1'b0;
  logic [CNT_W-1:0] special_cnt;

  bf16_operand_unpack #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .a_sign(a_sign), .b_sign(b_sign), .prod_sign(prod_sign),
    .a_exp(a_exp), .b_exp(b_exp), .a_man(a_man), .b_man(b_man),
    .a_cls(a_cls), .b_cls(b_cls), .special_valid(special_valid),
    .special_result(special_result), .cnt_clr(cnt_clr), .special_cnt(special_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  int acc_cnt = 0;
  int xfer_cnt = 0;
  int model_cnt = 0;
  int ready_mode = 0;

  wire [63:0] dut_vec = {a_sign, b_sign, prod_sign, a_exp, b_exp, a_man, b_man,
                         a_cls, b_cls, special_valid, special_result};

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic int classify(input logic [15:0] x);
    int e = int'(x[14:7]);
    int m = int'(x[6:0]);
    if (e == 255) return (m == 0) ? C_INF : C_NAN;
    if (e == 0 && m == 0) return C_ZERO;
    if (e == 0) return DAZ ? C_ZERO : C_SUB;
    return C_NORM;
  endfunction

  function automatic logic [9:0] op_exp(input logic [15:0] x, input int c);
    if (c == C_ZERO) return 10'd0;
    if (c == C_SUB) return 10'd1;
    return 10'(x[14:7]);
  endfunction

  function automatic logic [7:0] op_man(input logic [15:0] x, input int c);
    if (c == C_ZERO) return 8'd0;
    if (c == C_SUB) return 8'(x[6:0]);
    return 8'd128 + 8'(x[6:0]);
  endfunction

  function automatic logic [3:0] cls_bits(input int c);
    case (c)
      C_NAN:   return 4'd8;
      C_INF:   return 4'd4;
      C_SUB:   return 4'd2;
      C_ZERO:  return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [63:0] model(input logic [15:0] a, input logic [15:0] b);
    int ca = classify(a);
    int cb = classify(b);
    logic ps = a[15] ^ b[15];
    logic sv;
    logic [15:0] res;
    if (ca == C_NAN || cb == C_NAN || (ca == C_INF && cb == C_ZERO) || (cb == C_INF && ca == C_ZERO)) begin
      sv = 1'b1; res = 16'h7FC0;
    end else if (ca == C_INF || cb == C_INF) begin
      sv = 1'b1; res = ps ? 16'hFF80 : 16'h7F80;
    end else if (ca == C_ZERO || cb == C_ZERO) begin
      sv = 1'b1; res = ps ? 16'h8000 : 16'h0000;
    end else begin
      sv = 1'b0; res = 16'h0000;
    end
    return {a[15], b[15], ps, op_exp(a, ca), op_exp(b, cb), op_man(a, ca), op_man(b, cb),
            cls_bits(ca), cls_bits(cb), sv, res};
  endfunction

  function automatic logic [15:0] rand_op();
    logic s = 1'($urandom_range(0, 1));
    logic [6:0] m = 7'($urandom);
    logic [7:0] e = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 5))
      0:       return {s, 8'h00, 7'h00};
      1:       return {s, 8'h00, (m == 7'h00) ? 7'h01 : m};
      2:       return {s, 8'hFF, 7'h00};
      3:       return {s, 8'hFF, (m == 7'h00) ? 7'h40 : m};
      default: return {s, e, m};
    endcase
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    bit acc = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (acc) begin
      exp_q.push_back(model(a, b));
      acc_cnt++;
    end else begin
      fail_now("send_timeout");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops expectations on transfers, checks hold during stalls, tracks counter and occupancy.
  logic [64:0] prev_vec = '0;
  bit prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [63:0] e;
    bit spec_xfer;
    spec_xfer = 1'b0;
    if (!rst_n) begin
      prev_stall = 1'b0;
      model_cnt = 0;
    end else begin
      check("special_cnt", 65'(special_cnt), 65'(model_cnt));
      check("in_ready", 65'(in_ready), 65'(!((acc_cnt - xfer_cnt) == 2 && !out_ready)));
      if (prev_stall) check("stall_hold", {out_valid, dut_vec}, prev_vec);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected none", dut_vec);
        end else begin
          e = exp_q.pop_front();
          check("pair", 65'(dut_vec), 65'(e));
          spec_xfer = e[16];
        end
        xfer_cnt++;
      end
      if (cnt_clr) model_cnt = 0;
      else if (spec_xfer && model_cnt < CNT_MAX) model_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_vec = {out_valid, dut_vec};
    end
  end

  initial begin
    #1;
    check("reset_out_valid", 65'(out_valid), 65'd0);
    check("reset_cnt", 65'(special_cnt), 65'd0);
    check("reset_in_ready", 65'(in_ready), 65'd1);
    check("reset_data", 65'(dut_vec), 65'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    ready_mode = 0;
    send(16'h3F80, 16'h4000);
    send(16'h7F80, 16'h0000);
    send(16'h7F80, 16'hBF80);
    send(16'h0001, 16'h3F80);
    drain();

    ready_mode = 1;
    for (int i = 0; i < 8; i++) send(rand_op(), rand_op());
    drain();

    ready_mode = 2;
    for (int i = 0; i < 200; i++) begin
      send(rand_op(), rand_op());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    ready_mode = 0;
    for (int i = 0; i < CNT_MAX + 5; i++)
      send({1'($urandom_range(0, 1)), 8'hFF, 7'h00}, {1'($urandom_range(0, 1)), 15'h0000});
    drain();
    @(negedge clk);
    check("cnt_saturated", 65'(special_cnt), 65'(CNT_MAX));

    // Fill both stages under a stall, then reset asynchronously.
    ready_mode = 3;
    @(posedge clk);
    #1;
    send(16'h3F80, 16'h7F80);
    send(16'hC000, 16'h0000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("full_in_ready", 65'(in_ready), 65'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 65'(out_valid), 65'd0);
    check("rst_cnt", 65'(special_cnt), 65'd0);
    check("rst_data", 65'(dut_vec), 65'd0);
    check("rst_in_ready", 65'(in_ready), 65'd1);
    exp_q.delete();
    acc_cnt = xfer_cnt;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    ready_mode = 0;
    #1;
    check("post_rst_in_ready", 65'(in_ready), 65'd1);
    repeat (10) @(posedge clk);
    #1;

    // Clear coinciding with special transfers.
    for (int i = 0; i < 3; i++) send(16'hFFC1, 16'h3F80);
    drain();
    cnt_clr = 1'b1;
    send(16'h7F80, 16'h8000);
    drain();
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    check("cnt_cleared", 65'(special_cnt), 65'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bf16_operand_unpack.md
# bf16_operand_unpack

Elastic two-stage pipeline that accepts a pair of bfloat16 operands and decodes them into the internal form used by the approximate multiplier datapath. Each operand produces a sign, a 10-bit biased exponent, and an 8-bit mantissa with the hidden bit restored, plus class flags. It also resolves special-case products (NaN, infinity, zero) early, as a bypass result. It sits at the multiplier input and is the decode counterpart of the output-side exception/pack stage, which consumes the same 10-bit exponent and 8-bit mantissa formats.

## Interface
Parameters:
- CNT_W, 16, width of the saturating special-case counter

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operand pair
- a_in  input  16  operand A, bfloat16 {sign, exp[7:0], man[6:0]}
- b_in  input  16  operand B, bfloat16
- out_valid  output  1  decoded pair valid
- out_ready  input  1  downstream accepts decoded pair
- a_sign, b_sign  output  1  operand signs
- prod_sign  output  1  a_sign ^ b_sign
- a_exp, b_exp  output  10  biased exponent, zero-extended; forced to 10'd1 for subnormals
- a_man, b_man  output  8  {hidden, man[6:0]}; hidden = (exp != 0)
- a_cls, b_cls  output  4  {nan, inf, sub, zero}, one-hot or all-zero for normal
- special_valid  output  1  product is fully determined by the special-case logic
- special_result  output  16  bfloat16 bypass product, meaningful when special_valid
- cnt_clr  input  1  synchronous clear of special_cnt
- special_cnt  output  CNT_W  saturating count of transferred pairs with special_valid

## Operation
- Classes come from raw fields (E = exp, M = man):
  - zero: E=0, M=0
  - sub: E=0, M≠0
  - inf: E=FF, M=0
  - nan: E=FF, M≠0
  - otherwise normal.
- Special resolution is evaluated in priority order:
  - either nan, or (inf on one operand and zero on the other) → 16'h7FC0 (canonical NaN, sign 0)
  - else either inf → {prod_sign, 8'hFF, 7'h00}
  - else either zero → {prod_sign, 8'h00, 7'h00}
  - else special_valid = 0 and special_result = 16'h0000.
- special_cnt increments by 1 on each output transfer (out_valid && out_ready) with special_valid set. It saturates at all-ones.
- cnt_clr takes priority over increment; a cleared counter reads 0 the next cycle.
- Decode is pure combinational logic between stage 1 and stage 2. All outputs are driven from stage-2 registers only.

## Timing
- Stage 1 registers raw a_in and b_in. Stage 2 registers the decoded fields.
- s2_load = !s2_v || out_ready
- s1_load = !s1_v || s2_load
- in_ready = s1_load, computed combinationally from state and out_ready
- Latency: a pair accepted in cycle N appears with out_valid in cycle N+2 when there is no stall. Throughput is 1 pair/cycle.
- Stall: while out_valid && !out_ready, all outputs hold stable. Stage 1 can still fill, then in_ready drops. No data is lost or duplicated.
- A simultaneous accept and transfer in the same cycle keeps full throughput.
- Reset (asynchronous, any time, including mid-stall) drives:
  - s1_v = s2_v = 0, out_valid = 0
  - in_ready = 1 after reset
  - all data outputs 0, special_cnt = 0
- In-flight pairs are discarded on reset.

## Configuration
- BF16_DAZ_EN defined:
  - subnormal inputs are treated as zero
  - cls = zero (sub never asserted), exp = 10'd0, man = 8'h00
  - they participate in the zero/inf×zero special rules
- BF16_DAZ_EN undefined:
  - subnormals are passed through with exp = 10'd1 and hidden bit 0
  - cls = sub, and they do not trigger special resolution.

## Structure
- Shared package bf16_pkg holds:
  - field widths (EXP_W=8, MAN_W=7, EXP_INT_W=10)
  - bias 127
  - class bit indices
  - constants BF16_QNAN=16'h7FC0, BF16_EXP_MAX=8'hFF.
- One sub-module, bf16_field_decode: purely combinational decoder for a single 16-bit operand that outputs sign, exp, man and cls. It is instantiated twice.

## Test plan
- a=16'h3F80 (1.0), b=16'h4000 (2.0), out_ready=1 → after 2 cycles:
  - a_exp=10'd127, a_man=8'h80, b_exp=10'd128, b_man=8'h80
  - cls=0, special_valid=0, prod_sign=0.
- a=16'h7F80 (+inf), b=16'h0000 → special_result=16'h7FC0, special_cnt increments to 1. Repeat with b=16'hBF80 → special_result=16'hFF80.
- a=16'h0001 (subnormal), b=16'h3F80:
  - BF16_DAZ_EN undefined → a_cls=sub, a_exp=10'd1, a_man=8'h01, special_valid=0
  - BF16_DAZ_EN defined → a_cls=zero, special_result=16'h0000.
- Back-to-back stream of 8 pairs with out_ready toggling 1/0 each cycle:
  - all 8 outputs are in order and held stable during stalls
  - in_ready drops only when both stages are full.
- Saturation and clear:
  - preload via 2^CNT_W special transfers (CNT_W=4 build) → counter sticks at 4'hF
  - cnt_clr asserted together with a special transfer → counter reads 0.
- rst_n asserted low mid-stall with both stages full → outputs and counter 0 immediately, in_ready=1 after release, no stale pair emitted.
